// File: rtl/pong_match_controller.sv
// Pong game-flow sequencer: start-button edge detect, frame-tick timer,
// serve/play/pause/point/game-over sequencing, score and winner registers.
// Ports: clock, reset (async, active-high), frameTick, start_n, ballX[7:0] in;
//        ballReset, ballStep, paddleStep, serveDirection, leftScore[7:0],
//        rightScore[7:0], winner[1:0], gameOver, state[2:0] out.
module pong_match_controller #(
    parameter int WIN_SCORE      = 11,
    parameter int SERVE_TICKS    = 60,
    parameter int POINT_TICKS    = 90,
    parameter int GAMEOVER_TICKS = 300,
    parameter int X_LEFT_GOAL    = 5,
    parameter int X_RIGHT_GOAL   = 230
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frameTick,
    input  logic       start_n,
    input  logic [7:0] ballX,
    output logic       ballReset,
    output logic       ballStep,
    output logic       paddleStep,
    output logic       serveDirection,
    output logic [7:0] leftScore,
    output logic [7:0] rightScore,
    output logic [1:0] winner,
    output logic       gameOver,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        PAUSED    = 3'd3,
        POINT     = 3'd4,
        GAME_OVER = 3'd5
    } state_t;

    localparam logic [7:0] WIN     = 8'(WIN_SCORE);
    localparam logic [7:0] XL      = 8'(X_LEFT_GOAL);
    localparam logic [7:0] XR      = 8'(X_RIGHT_GOAL);
    localparam logic [9:0] SERVE_T = 10'(SERVE_TICKS);
    localparam logic [9:0] POINT_T = 10'(POINT_TICKS);
    localparam logic [9:0] OVER_T  = 10'(GAMEOVER_TICKS);

    state_t     cur;
    state_t     nxt;
    logic [9:0] timer;
    logic [9:0] timer_n;
    logic [7:0] left_n;
    logic [7:0] right_n;
    logic [7:0] left_inc;
    logic [7:0] right_inc;
    logic [1:0] win_n;
    logic       dir_n;
    logic       s1, s2, s3;
    logic       press;
    logic       goal_r;
    logic       goal_l;
    logic       goal;
    logic       expire;
    logic       timed;

    // Falling edge of the synchronised button.
    assign press     = s3 & ~s2;
    assign goal_r    = (ballX >= XR);
    assign goal_l    = (ballX <= XL);
    assign goal      = frameTick & (cur == PLAY) & (goal_r | goal_l);
    assign expire    = frameTick & (timer == 10'd1);
    assign timed     = (cur == SERVE) | (cur == POINT) | (cur == GAME_OVER);
    assign left_inc  = leftScore + 8'd1;
    assign right_inc = rightScore + 8'd1;

    always_comb begin
        nxt     = cur;
        timer_n = timer;
        left_n  = leftScore;
        right_n = rightScore;
        dir_n   = serveDirection;
        win_n   = winner;
        if (frameTick && timed && timer != 10'd0) begin
            timer_n = timer - 10'd1;
        end
        case (cur)
            IDLE: begin
                if (press) begin
                    nxt     = SERVE;
                    left_n  = 8'd0;
                    right_n = 8'd0;
                    win_n   = 2'b00;
                    dir_n   = 1'b1;
                    timer_n = SERVE_T;
                end
            end
            SERVE: begin
                if (expire) begin
                    nxt = PLAY;
                end
            end
            PLAY: begin
                // A goal on this tick swallows any coincident press.
                if (goal) begin
                    if (goal_r) begin
                        left_n = left_inc;
                        dir_n  = 1'b1;
                    end else begin
                        right_n = right_inc;
                        dir_n   = 1'b0;
                    end
                    if (goal_r && left_inc == WIN) begin
                        nxt     = GAME_OVER;
                        win_n   = 2'b10;
                        timer_n = OVER_T;
                    end else if (!goal_r && right_inc == WIN) begin
                        nxt     = GAME_OVER;
                        win_n   = 2'b01;
                        timer_n = OVER_T;
                    end else begin
                        nxt     = POINT;
                        timer_n = POINT_T;
                    end
                end else if (press) begin
                    nxt = PAUSED;
                end
            end
            PAUSED: begin
                if (press) begin
                    nxt = PLAY;
                end
            end
            POINT: begin
                if (expire) begin
                    nxt     = SERVE;
                    timer_n = SERVE_T;
                end
            end
            GAME_OVER: begin
                if (press) begin
                    nxt     = SERVE;
                    left_n  = 8'd0;
                    right_n = 8'd0;
                    win_n   = 2'b00;
                    dir_n   = 1'b1;
                    timer_n = SERVE_T;
                end else if (expire) begin
                    nxt = IDLE;
                end
            end
            default: begin
                nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur            <= IDLE;
            timer          <= 10'd0;
            leftScore      <= 8'd0;
            rightScore     <= 8'd0;
            winner         <= 2'b00;
            serveDirection <= 1'b1;
            ballReset      <= 1'b1;
            ballStep       <= 1'b0;
            paddleStep     <= 1'b0;
            s1             <= 1'b1;
            s2             <= 1'b1;
            s3             <= 1'b1;
        end else begin
            cur            <= nxt;
            timer          <= timer_n;
            leftScore      <= left_n;
            rightScore     <= right_n;
            winner         <= win_n;
            serveDirection <= dir_n;
            ballReset      <= !((nxt == PLAY) || (nxt == PAUSED));
            ballStep       <= frameTick & (cur == PLAY) & ~goal;
            paddleStep     <= frameTick & ((cur == SERVE) | (cur == PLAY));
            s1             <= start_n;
            s2             <= s1;
            s3             <= s2;
        end
    end

    assign gameOver = (cur == GAME_OVER);
    assign state    = cur;

endmodule

// File: tb/tb_pong_match_controller.sv
// Randomised bench for pong_match_controller against a behavioural model,
// with directed scenarios pinned by hand-computed expectations.
module tb_pong_match_controller;

    localparam int WIN = 3;
    localparam int ST  = 2;
    localparam int PT  = 3;
    localparam int GT  = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       frameTick;
    logic       start_n;
    logic [7:0] ballX;
    logic       ballReset, ballStep, paddleStep, serveDirection, gameOver;
    logic [7:0] leftScore, rightScore;
    logic [1:0] winner;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    pong_match_controller #(
        .WIN_SCORE(WIN), .SERVE_TICKS(ST), .POINT_TICKS(PT),
        .GAMEOVER_TICKS(GT), .X_LEFT_GOAL(5), .X_RIGHT_GOAL(230)
    ) dut (
        .clock(clock), .reset(reset), .frameTick(frameTick),
        .start_n(start_n), .ballX(ballX), .ballReset(ballReset),
        .ballStep(ballStep), .paddleStep(paddleStep),
        .serveDirection(serveDirection), .leftScore(leftScore),
        .rightScore(rightScore), .winner(winner), .gameOver(gameOver),
        .state(state)
    );

    always #5 clock = ~clock;

    // Behavioural model: states as plain ints, ticks remaining as a count,
    // button history as the last three sampled levels (h[0] newest).
    int       m_state, m_rem, m_left, m_right;
    bit       m_sd, m_bs, m_ps;
    bit [1:0] m_win;
    bit       h[3];
    bit       m_press;

    task automatic begin_match();
        m_state = 1; m_left = 0; m_right = 0; m_win = 2'b00;
        m_sd = 1'b1; m_rem = ST;
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_state = 0; m_rem = 0; m_left = 0; m_right = 0;
            m_sd = 1'b1; m_bs = 1'b0; m_ps = 1'b0; m_win = 2'b00;
            h[0] = 1'b1; h[1] = 1'b1; h[2] = 1'b1;
        end else begin
            m_press = (h[1] == 1'b0) && (h[2] == 1'b1);
            h[2] = h[1]; h[1] = h[0]; h[0] = start_n;
            m_bs = 1'b0;
            m_ps = 1'b0;
            case (m_state)
                0: if (m_press) begin_match();
                1: begin
                    m_ps = frameTick;
                    if (frameTick) begin
                        m_rem--;
                        if (m_rem == 0) m_state = 2;
                    end
                end
                2: begin
                    m_ps = frameTick;
                    if (frameTick && (ballX >= 230 || ballX <= 5)) begin
                        if (ballX >= 230) begin m_left++; m_sd = 1'b1; end
                        else begin m_right++; m_sd = 1'b0; end
                        if (m_left == WIN || m_right == WIN) begin
                            m_state = 5; m_rem = GT;
                            m_win = {m_left == WIN, m_right == WIN};
                        end else begin
                            m_state = 4; m_rem = PT;
                        end
                    end else begin
                        m_bs = frameTick;
                        if (m_press) m_state = 3;
                    end
                end
                3: if (m_press) m_state = 2;
                4: if (frameTick) begin
                    m_rem--;
                    if (m_rem == 0) begin m_state = 1; m_rem = ST; end
                end
                5: begin
                    if (m_press) begin_match();
                    else if (frameTick) begin
                        m_rem--;
                        if (m_rem == 0) m_state = 0;
                    end
                end
                default: m_state = 0;
            endcase
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            chk("state", state, m_state);
            chk("ballReset", ballReset, (m_state == 2 || m_state == 3) ? 0 : 1);
            chk("ballStep", ballStep, m_bs);
            chk("paddleStep", paddleStep, m_ps);
            chk("serveDirection", serveDirection, m_sd);
            chk("leftScore", leftScore, m_left);
            chk("rightScore", rightScore, m_right);
            chk("winner", winner, m_win);
            chk("gameOver", gameOver, m_state == 5);
        end
    end

    task automatic cycle(input logic sn, input logic [7:0] bx);
        start_n   = sn;
        ballX     = bx;
        frameTick = (cyc % 8 == 7);
        @(negedge clock);
        cyc++;
    endtask

    task automatic next_tick(input logic [7:0] bx);
        while (cyc % 8 != 7) cycle(1'b1, 8'd120);
        cycle(1'b1, bx);
    endtask

    task automatic press();
        repeat (4) cycle(1'b0, 8'd120);
        cycle(1'b1, 8'd120);
    endtask

    task automatic goto_play();
        for (int i = 0; i < 20 && m_state != 2; i++) next_tick(8'd120);
        chk("reach_play", state, 2);
    endtask

    task automatic check_reset_vals();
        chk("rst_state", state, 0);
        chk("rst_ballReset", ballReset, 1);
        chk("rst_ballStep", ballStep, 0);
        chk("rst_paddleStep", paddleStep, 0);
        chk("rst_dir", serveDirection, 1);
        chk("rst_left", leftScore, 0);
        chk("rst_right", rightScore, 0);
        chk("rst_winner", winner, 0);
        chk("rst_gameOver", gameOver, 0);
    endtask

    // Called right after a falling edge; reset takes effect immediately.
    task automatic do_reset();
        start_n = 1'b1;
        reset   = 1'b1;
        #1;
        check_reset_vals();
        @(negedge clock);
        #1 reset = 1'b0;
        cyc = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int low_left;
        logic [7:0] bx;
        reset = 1'b1; start_n = 1'b1; frameTick = 1'b0; ballX = 8'd120;
        @(negedge clock);
        check_reset_vals();
        #1 reset = 1'b0;

        // Start press: state changes on the third edge only.
        cycle(1'b0, 8'd120);
        cycle(1'b0, 8'd120);
        chk("t1_edge2", state, 0);
        cycle(1'b0, 8'd120);
        chk("t1_edge3", state, 1);
        cycle(1'b0, 8'd120);
        cycle(1'b0, 8'd120);
        chk("t1_one_press", state, 1);
        next_tick(8'd120);
        next_tick(8'd120);
        chk("t1_play", state, 2);
        chk("t1_ballReset", ballReset, 0);

        // Left goal at the exact boundary.
        next_tick(8'd230);
        chk("t2_left", leftScore, 1);
        chk("t2_state", state, 4);
        chk("t2_dir", serveDirection, 1);
        chk("t2_noStep", ballStep, 0);
        repeat (3) next_tick(8'd120);
        chk("t2_serve", state, 1);
        repeat (2) next_tick(8'd120);
        chk("t2_play", state, 2);

        // Right goal boundary and the non-goal neighbours.
        next_tick(8'd5);
        chk("t3_right", rightScore, 1);
        chk("t3_dir", serveDirection, 0);
        chk("t3_state", state, 4);
        goto_play();
        next_tick(8'd6);
        chk("t3_step6", ballStep, 1);
        chk("t3_right_held", rightScore, 1);
        cycle(1'b1, 8'd120);
        chk("t3_step_single", ballStep, 0);
        next_tick(8'd229);
        chk("t3_step229", ballStep, 1);
        chk("t3_left_held", leftScore, 1);

        // Pause and resume; press coinciding with a goal.
        press();
        chk("t5_paused", state, 3);
        repeat (3) begin
            next_tick(8'd120);
            chk("t5_noBall", ballStep, 0);
            chk("t5_noPaddle", paddleStep, 0);
        end
        press();
        chk("t5_resume", state, 2);
        cycle(1'b1, 8'd120);
        cycle(1'b1, 8'd120);
        while (cyc % 8 != 5) cycle(1'b1, 8'd120);
        cycle(1'b0, 8'd120);
        cycle(1'b0, 8'd120);
        cycle(1'b0, 8'd230);
        chk("t5_goal_wins", state, 4);
        chk("t5_left2", leftScore, 2);

        // Reset in the middle of POINT.
        do_reset();

        // Presses during SERVE are ignored.
        press();
        chk("t6_serve", state, 1);
        press();
        chk("t6_serve_ignore", state, 1);

        // Left wins the match.
        goto_play();
        next_tick(8'd240);
        goto_play();
        next_tick(8'd240);
        goto_play();
        next_tick(8'd240);
        chk("t4_over", state, 5);
        chk("t4_winner", winner, 2);
        chk("t4_gameOver", gameOver, 1);
        chk("t4_left3", leftScore, 3);
        repeat (3) next_tick(8'd120);
        chk("t4_still_over", state, 5);
        next_tick(8'd120);
        chk("t4_idle", state, 0);
        chk("t4_held", leftScore, 3);
        chk("t4_win_held", winner, 2);
        press();
        chk("t4_restart", state, 1);
        chk("t4_cleared", leftScore, 0);
        chk("t4_win_clr", winner, 0);

        // Randomised play against the model.
        low_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 1999) == 0) begin
                do_reset();
                low_left = 0;
            end
            if (low_left == 0 && $urandom_range(0, 39) == 0)
                low_left = $urandom_range(1, 6);
            case ($urandom_range(0, 3))
                0: bx = 8'($urandom_range(0, 6));
                1: bx = 8'($urandom_range(229, 255));
                default: bx = 8'($urandom_range(7, 228));
            endcase
            if (low_left > 0) begin
                low_left--;
                cycle(1'b0, bx);
            end else begin
                cycle(1'b1, bx);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pong_match_controller.md
# pong_match_controller

- Game-flow sequencer for the Pong datapath: idle/attract, serve, play, pause, point, game over.
- Sits between the refresh-rate tick generator and the ball/paddle movers.
- Owns the ball reset, ball and paddle step enables, serve direction and both score registers.
- Replaces ad-hoc score/reset logic clocked from refresh ticks; everything runs on the system clock with tick enables.

## Interface
Parameters:
- WIN_SCORE, 11, score that ends a match (1..255)
- SERVE_TICKS, 60, frame ticks spent in SERVE (≥1)
- POINT_TICKS, 90, frame ticks spent in POINT (≥1)
- GAMEOVER_TICKS, 300, frame ticks before GAME_OVER returns to IDLE (≥1, ≤1023)
- X_LEFT_GOAL, 5, ballX at or below this = right player scores
- X_RIGHT_GOAL, 230, ballX at or above this = left player scores

Ports:
- clock  in  1  system clock (50 MHz). Single clock; reset is asynchronous and active-high.
- reset  in  1  asynchronous, active-high reset.
- frameTick  in  1  one-cycle pulse per game refresh.
- start_n  in  1  raw active-low start/pause button.
- ballX  in  8  current ball x position.
- ballReset  out  1  hold ball at centre.
- ballStep  out  1  one-cycle ball move enable.
- paddleStep  out  1  one-cycle paddle move enable.
- serveDirection  out  1  1 = serve toward right, 0 = toward left.
- leftScore  out  8  left player score.
- rightScore  out  8  right player score.
- winner  out  2  bit1 = left won, bit0 = right won, 00 = none.
- gameOver  out  1  high in GAME_OVER.
- state  out  3  current state encoding.

## Operation
States and encodings: IDLE=0, SERVE=1, PLAY=2, PAUSED=3, POINT=4, GAME_OVER=5.

Start press detection:
- start_n passes through a 2-flop synchroniser (s1, s2) plus a history flop s3.
- press = s3 & ~s2, i.e. the falling edge.

Timer:
- 10-bit down-counter, decremented only on frameTick.
- A timed state exits on the frameTick where timer==1. SERVE therefore lasts exactly SERVE_TICKS ticks; likewise POINT and GAME_OVER with their parameters.

Transitions:
- IDLE: press → SERVE; scores cleared, winner=00, serveDirection=1, timer=SERVE_TICKS.
- SERVE: expiry → PLAY.
- PLAY, goal checked only on frameTick:
  - ballX ≥ X_RIGHT_GOAL: leftScore+1, serveDirection=1.
  - Else ballX ≤ X_LEFT_GOAL: rightScore+1, serveDirection=0. Right goal has priority if both conditions are true.
  - Incremented score == WIN_SCORE → GAME_OVER, winner bit set, timer=GAMEOVER_TICKS.
  - Otherwise → POINT, timer=POINT_TICKS.
- PLAY: press with no goal on the same cycle → PAUSED. If a goal and a press coincide, the goal wins and the press is discarded.
- PAUSED: press → PLAY. The timer is untouched.
- POINT: expiry → SERVE, timer=SERVE_TICKS.
- GAME_OVER:
  - press → SERVE with the same initialisation as from IDLE.
  - expiry → IDLE. Scores and winner are held for display.
- Presses in SERVE and POINT are ignored.

Outputs per state:
- ballReset = 1 in every state except PLAY and PAUSED.
- ballStep = registered (frameTick & state==PLAY & no goal this tick).
- paddleStep = registered (frameTick & state∈{SERVE, PLAY}).
- gameOver = (state==GAME_OVER).

Arithmetic:
- Scores are 8-bit and never exceed WIN_SCORE; no wrap is possible.
- The timer is loaded from the parameters truncated to 10 bits.

## Timing
- Reset values: state=IDLE, ballReset=1, ballStep=0, paddleStep=0, serveDirection=1, leftScore=0, rightScore=0, winner=00, gameOver=0, timer=0, s1=s2=s3=1.
- Reset mid-operation: immediate return to IDLE with the values above, and any pending press is lost.
- start_n going low is captured by edge 1 (s1) and edge 2 (s2). The state changes at edge 3. A low held for more than 3 cycles produces exactly one press.
- frameTick sampled at edge N: the state/score update and the registered ballStep/paddleStep pulses all appear after edge N.
- Both step outputs are single-cycle and only ever issue one cycle after a frameTick.
- ballX is sampled in the same cycle as frameTick; no pipelining on the goal check.
- All outputs are registered except gameOver, which is decoded directly from the state register.

## Test plan
Bench parameters: WIN_SCORE=3, SERVE_TICKS=2, POINT_TICKS=3, GAMEOVER_TICKS=4; frameTick every 8 cycles.

1. Reset, then hold start_n low 5 cycles → exactly one press; state 0→1 on the 3rd edge; scores 0; serveDirection=1; after 2 frameTicks state=2 and ballReset drops.
2. In PLAY, frameTick with ballX=230 → leftScore=1, state=4, serveDirection=1, no ballStep. After 3 ticks state=1; after 2 more, state=2.
3. In PLAY, ballX=5 on tick → rightScore+1, serveDirection=0. ballX=6 or 229 on tick → no score and ballStep pulses one cycle later.
4. Drive left goals until leftScore=3 → state=5, winner=10, gameOver=1. After 4 ticks state=0 with scores held at 3/x. A new press clears the scores.
5. Press in PLAY → PAUSED: no ballStep or paddleStep across 3 ticks. Press again → PLAY. A press on the same cycle as a goal tick → POINT, not PAUSED.
6. Assert reset during POINT with leftScore=2 → all outputs at reset values in the same cycle. Presses in SERVE/POINT produce no state change.
